// File: rtl/dcache_req_arbiter_if.sv
// Request/enqueue bundle for the DCache internal-request arbiter.
// Signal names match the original flat port list; the arbiter uses the slave side.
interface dcache_req_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 64,
  parameter int BR_W      = 16,
  parameter int Q_ENTRIES = 16
);
  localparam int QC_W  = $clog2(Q_ENTRIES) + 1;
  localparam int SRC_W = $clog2(NREQ);

  logic                   io_flush;
  logic [BR_W-1:0]        io_br_resolve_mask;
  logic [BR_W-1:0]        io_br_kill_mask;
  logic [NREQ-1:0]        io_req_valid;
  logic [NREQ-1:0]        io_req_ready;
  logic [NREQ*DATA_W-1:0] io_req_data;
  logic [NREQ*BR_W-1:0]   io_req_br_mask;
  logic [NREQ-1:0]        io_req_uses_ldq;
  logic [QC_W-1:0]        io_q_count;
  logic                   io_enq_valid;
  logic                   io_enq_ready;
  logic [DATA_W-1:0]      io_enq_data;
  logic [BR_W-1:0]        io_enq_br_mask;
  logic                   io_enq_uses_ldq;
  logic [SRC_W-1:0]       io_enq_src;

  modport master (
    output io_flush, io_br_resolve_mask, io_br_kill_mask, io_req_valid,
           io_req_data, io_req_br_mask, io_req_uses_ldq, io_q_count, io_enq_ready,
    input  io_req_ready, io_enq_valid, io_enq_data, io_enq_br_mask,
           io_enq_uses_ldq, io_enq_src
  );

  modport slave (
    input  io_flush, io_br_resolve_mask, io_br_kill_mask, io_req_valid,
           io_req_data, io_req_br_mask, io_req_uses_ldq, io_q_count, io_enq_ready,
    output io_req_ready, io_enq_valid, io_enq_data, io_enq_br_mask,
           io_enq_uses_ldq, io_enq_src
  );
endinterface

// File: rtl/dcache_req_arbiter.sv
// Arbitrates NREQ one-entry holding slots onto the DCache internal-request queue:
// round-robin with starvation override, branch/flush kill tracking, slot-0 reserve.
module dcache_req_arbiter #(
  parameter int NREQ         = 4,
  parameter int DATA_W       = 64,
  parameter int BR_W         = 16,
  parameter int Q_ENTRIES    = 16,
  parameter int RESERVE      = 2,
  parameter int STARVE_LIMIT = 7
) (
  input logic              clock,
  input logic              reset,
  dcache_req_arbiter_if.slave bus
);
  localparam int SRC_W = $clog2(NREQ);
  localparam int QC_W  = $clog2(Q_ENTRIES) + 1;
  localparam int CW    = $clog2(STARVE_LIMIT + 1);

  logic [NREQ-1:0]   slot_valid;
  logic [DATA_W-1:0] slot_data [NREQ];
  logic [BR_W-1:0]   slot_mask [NREQ];
  logic [NREQ-1:0]   slot_ldq;
  logic [CW-1:0]     wait_cnt  [NREQ];
  logic [SRC_W-1:0]  rr_ptr;

  logic              throttle;
  logic [NREQ-1:0]   killed;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   starved;
  logic [NREQ-1:0]   grant;
  logic [SRC_W-1:0]  win;
  logic [SRC_W-1:0]  cand;
  logic              found;
  logic              fire;

  always_comb begin
    throttle = bus.io_q_count >= QC_W'(Q_ENTRIES - RESERVE);
    for (int unsigned i = 0; i < NREQ; i++) begin
      killed[i]  = (|(slot_mask[i] & bus.io_br_kill_mask)) | (bus.io_flush & slot_ldq[i]);
      elig[i]    = slot_valid[i] & ~killed[i] & ((i == 0) | ~throttle);
      starved[i] = elig[i] & (wait_cnt[i] == CW'(STARVE_LIMIT));
    end
  end

  // Starved slots win by lowest index; otherwise first eligible at or after rr_ptr.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (starved[i] && !found) begin
        win   = SRC_W'(i);
        found = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = SRC_W'((32'(rr_ptr) + k) % NREQ);
      if (elig[cand] && !found) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    fire = found & bus.io_enq_ready;
    for (int unsigned i = 0; i < NREQ; i++) grant[i] = fire & (win == SRC_W'(i));
    bus.io_req_ready    = ~slot_valid;
    bus.io_enq_valid    = found;
    bus.io_enq_data     = '0;
    bus.io_enq_br_mask  = '0;
    bus.io_enq_uses_ldq = 1'b0;
    bus.io_enq_src      = '0;
    if (found) begin
      bus.io_enq_data     = slot_data[win];
      bus.io_enq_br_mask  = slot_mask[win] & ~bus.io_br_resolve_mask;
      bus.io_enq_uses_ldq = slot_ldq[win];
      bus.io_enq_src      = win;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid <= '0;
      slot_ldq   <= '0;
      rr_ptr     <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        slot_data[i] <= '0;
        slot_mask[i] <= '0;
        wait_cnt[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (slot_valid[i]) begin
          slot_mask[i] <= slot_mask[i] & ~bus.io_br_resolve_mask;
          if (grant[i] || killed[i]) begin
            slot_valid[i] <= 1'b0;
            wait_cnt[i]   <= '0;
          end else if (wait_cnt[i] != CW'(STARVE_LIMIT)) begin
            wait_cnt[i] <= wait_cnt[i] + 1'b1;
          end
        end else begin
          wait_cnt[i] <= '0;
          if (bus.io_req_valid[i]) begin
            // Killed/flushed arrivals are still handshaken, just never held.
            slot_valid[i] <= ~(|(bus.io_req_br_mask[i*BR_W +: BR_W] & bus.io_br_kill_mask))
                             & ~(bus.io_flush & bus.io_req_uses_ldq[i]);
            slot_data[i]  <= bus.io_req_data[i*DATA_W +: DATA_W];
            slot_mask[i]  <= bus.io_req_br_mask[i*BR_W +: BR_W] & ~bus.io_br_resolve_mask;
            slot_ldq[i]   <= bus.io_req_uses_ldq[i];
          end
        end
      end
      if (fire) begin
        if (32'(win) == NREQ - 1) rr_ptr <= '0;
        else                      rr_ptr <= win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a slot-level behavioural model.
module tb_dcache_req_arbiter;
  localparam int NREQ = 4, DATA_W = 64, BR_W = 16, QE = 16, RES = 2, LIMIT = 7;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dcache_req_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .BR_W(BR_W), .Q_ENTRIES(QE)) bus ();

  dcache_req_arbiter #(
    .NREQ(NREQ), .DATA_W(DATA_W), .BR_W(BR_W), .Q_ENTRIES(QE),
    .RESERVE(RES), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: one record per requester
  bit          m_valid [NREQ];
  logic [63:0] m_data  [NREQ];
  logic [15:0] m_mask  [NREQ];
  bit          m_ldq   [NREQ];
  int          m_age   [NREQ];
  int          m_rr;
  bit          el [NREQ];
  bit          gone [NREQ];
  int          w, best, d;
  logic [3:0]  exp_ready;
  logic [15:0] rm;

  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_ready", bus.io_req_ready, 4'hF);
      chk("rst_valid", bus.io_enq_valid, 0);
      chk("rst_src",   bus.io_enq_src, 0);
      chk("rst_data",  bus.io_enq_data, 0);
      chk("rst_mask",  bus.io_enq_br_mask, 0);
      chk("rst_ldq",   bus.io_enq_uses_ldq, 0);
      for (int i = 0; i < NREQ; i++) begin m_valid[i] = 0; m_age[i] = 0; end
      m_rr = 0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        gone[i] = m_valid[i] && (((m_mask[i] & bus.io_br_kill_mask) != 0) ||
                                 (bus.io_flush && m_ldq[i]));
        el[i]   = m_valid[i] && !gone[i] && (i == 0 || bus.io_q_count < QE - RES);
        exp_ready[i] = !m_valid[i];
      end
      w = -1;
      for (int i = 0; i < NREQ; i++) if (w < 0 && el[i] && m_age[i] >= LIMIT) w = i;
      if (w < 0) begin
        best = NREQ;
        for (int i = 0; i < NREQ; i++) begin
          d = (i - m_rr + NREQ) % NREQ;
          if (el[i] && d < best) begin best = d; w = i; end
        end
      end
      chk("ready", bus.io_req_ready, exp_ready);
      chk("enq_valid", bus.io_enq_valid, w >= 0);
      chk("enq_src",   bus.io_enq_src,  (w >= 0) ? w : 0);
      chk("enq_data",  bus.io_enq_data, (w >= 0) ? m_data[w] : 0);
      chk("enq_mask",  bus.io_enq_br_mask, (w >= 0) ? (m_mask[w] & ~bus.io_br_resolve_mask) : 0);
      chk("enq_ldq",   bus.io_enq_uses_ldq, (w >= 0) ? m_ldq[w] : 0);
      for (int i = 0; i < NREQ; i++) begin
        if (m_valid[i]) begin
          if (gone[i] || (w == i && bus.io_enq_ready)) m_valid[i] = 0;
          m_mask[i] &= ~bus.io_br_resolve_mask;
          m_age[i] = (m_age[i] + 1 > LIMIT) ? LIMIT : m_age[i] + 1;
        end else if (bus.io_req_valid[i]) begin
          rm = bus.io_req_br_mask[i*BR_W +: BR_W];
          m_valid[i] = ((rm & bus.io_br_kill_mask) == 0) && !(bus.io_flush && bus.io_req_uses_ldq[i]);
          m_data[i]  = bus.io_req_data[i*DATA_W +: DATA_W];
          m_mask[i]  = rm & ~bus.io_br_resolve_mask;
          m_ldq[i]   = bus.io_req_uses_ldq[i];
          m_age[i]   = 0;
        end
      end
      if (w >= 0 && bus.io_enq_ready) m_rr = (w + 1) % NREQ;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_req();
    bus.io_req_valid    = '0;
    bus.io_req_data     = '0;
    bus.io_req_br_mask  = '0;
    bus.io_req_uses_ldq = '0;
  endtask

  task automatic put(input int i, input logic [15:0] m, input bit ldq);
    bus.io_req_valid[i]              = 1'b1;
    bus.io_req_data[i*DATA_W +: 64]  = 64'hA0 + 64'(i);
    bus.io_req_br_mask[i*BR_W +: 16] = m;
    bus.io_req_uses_ldq[i]           = ldq;
  endtask

  initial begin
    clear_req();
    bus.io_flush = 0; bus.io_br_resolve_mask = '0; bus.io_br_kill_mask = '0;
    bus.io_q_count = '0; bus.io_enq_ready = 0;
    cyc(); cyc();
    reset = 1;

    // Round-robin: all four captured together, granted 0..3
    for (int i = 0; i < NREQ; i++) put(i, 16'h0, 0);
    cyc(); clear_req(); bus.io_enq_ready = 1;
    for (int k = 0; k < NREQ; k++) begin
      #3 chk("rr_valid", bus.io_enq_valid, 1); chk("rr_src", bus.io_enq_src, k);
      chk("rr_data", bus.io_enq_data, 64'hA0 + 64'(k));
      cyc();
    end
    #3 chk("rr_empty_valid", bus.io_enq_valid, 0); chk("rr_empty_ready", bus.io_req_ready, 4'hF);

    // Kill of the rr winner (slot 2) hands the grant to slot 3
    cyc(); put(2, 16'h0004, 0); put(3, 16'h0, 0); bus.io_enq_ready = 0;
    cyc(); clear_req(); bus.io_br_kill_mask = 16'h0004;
    #3 chk("kill_valid", bus.io_enq_valid, 1); chk("kill_src", bus.io_enq_src, 3);
    cyc(); bus.io_br_kill_mask = '0; bus.io_enq_ready = 1;
    #3 chk("kill_src2", bus.io_enq_src, 3);
    cyc(); bus.io_enq_ready = 0;
    #3 chk("kill_done", bus.io_enq_valid, 0); chk("kill_ready", bus.io_req_ready, 4'hF);

    // Resolve clears bits in the offered mask; resolved bit no longer kills
    cyc(); put(1, 16'h0006, 0);
    cyc(); clear_req(); bus.io_br_resolve_mask = 16'h0002; bus.io_enq_ready = 1;
    #3 chk("res_src", bus.io_enq_src, 1); chk("res_mask", bus.io_enq_br_mask, 16'h0004);
    cyc(); bus.io_br_resolve_mask = '0; bus.io_enq_ready = 0; put(1, 16'h0004, 0);
    cyc(); clear_req(); bus.io_br_kill_mask = 16'h0002;
    #3 chk("res_nokill_valid", bus.io_enq_valid, 1); chk("res_nokill_mask", bus.io_enq_br_mask, 16'h0004);
    cyc(); bus.io_br_kill_mask = '0; bus.io_enq_ready = 1;
    #3 chk("res_fire_src", bus.io_enq_src, 1);
    cyc(); bus.io_enq_ready = 0;

    // Flush drops the ldq op in slot 0; slot 3 still granted
    put(0, 16'h0, 1); put(3, 16'h0, 0);
    cyc(); clear_req(); bus.io_flush = 1; bus.io_enq_ready = 1;
    #3 chk("flush_src", bus.io_enq_src, 3); chk("flush_ldq", bus.io_enq_uses_ldq, 0);
    cyc(); put(1, 16'h0, 1);
    #3 chk("flush_empty", bus.io_enq_valid, 0);
    cyc(); clear_req(); bus.io_flush = 0;
    #3 chk("flush_cap_drop", bus.io_enq_valid, 0); chk("flush_cap_ready", bus.io_req_ready, 4'hF);

    // Throttle: only slot 0 may enqueue near full
    cyc(); bus.io_q_count = 5'd14; put(1, 16'h0, 0); put(2, 16'h0, 0);
    cyc(); clear_req();
    #3 chk("thr_block", bus.io_enq_valid, 0);
    cyc(); put(0, 16'h0, 0);
    cyc(); clear_req();
    #3 chk("thr_valid0", bus.io_enq_valid, 1); chk("thr_src0", bus.io_enq_src, 0);
    cyc(); bus.io_q_count = '0;
    #3 chk("thr_release", bus.io_enq_valid, 1);
    cyc(); cyc(); cyc();

    // Random traffic; mid-stream reset pulse
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        bus.io_req_valid[i]              = ($urandom_range(0, 1) == 1);
        bus.io_req_data[i*DATA_W +: 64]  = {$urandom, $urandom};
        bus.io_req_br_mask[i*BR_W +: 16] = 16'($urandom_range(0, 15));
        bus.io_req_uses_ldq[i]           = ($urandom_range(0, 1) == 1);
      end
      bus.io_br_kill_mask    = ($urandom_range(0, 9) == 0) ? 16'(1 << $urandom_range(0, 3)) : '0;
      bus.io_br_resolve_mask = ($urandom_range(0, 5) == 0) ? 16'(1 << $urandom_range(0, 3)) : '0;
      bus.io_flush           = ($urandom_range(0, 19) == 0);
      bus.io_q_count         = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(14, 16)) : 5'($urandom_range(0, 13));
      bus.io_enq_ready       = ($urandom_range(0, 9) < 4);
      if (c == 2000 || c == 2001) reset = 0;
      else reset = 1;
      if (c == 2001) begin
        #3 chk("mid_rst_ready", bus.io_req_ready, 4'hF); chk("mid_rst_valid", bus.io_enq_valid, 0);
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
